// File: rtl/btn_debouncer_pkg.sv
// Shared defaults and per-channel state encodings for the push-button debouncer.
// State encoding is {level, counting}, so bit 1 is the accepted level.
package btn_debouncer_pkg;

  localparam int NB_BTN_DEFAULT         = 4;
  localparam int NB_COUNTER_DEFAULT     = 14;
  localparam int DEBOUNCE_LIMIT_DEFAULT = 10000;
  localparam int DEBOUNCE_LIMIT_SIM     = 4;

  typedef enum logic [1:0] {
    ST_LOW       = 2'b00,
    ST_WAIT_HIGH = 2'b01,
    ST_HIGH      = 2'b10,
    ST_WAIT_LOW  = 2'b11
  } state_e;

endpackage

// File: rtl/btn_debouncer_if.sv
// Raw button lines in, debounced level and edge pulses out.
interface btn_debouncer_if
  import btn_debouncer_pkg::*;
#(
  parameter int NB_BTN = NB_BTN_DEFAULT
);

  logic [NB_BTN-1:0] i_btn;
  logic [NB_BTN-1:0] o_level;
  logic [NB_BTN-1:0] o_press;
  logic [NB_BTN-1:0] o_release;

  modport master (output i_btn, input o_level, input o_press, input o_release);
  modport slave  (input i_btn, output o_level, output o_press, output o_release);

endinterface

// File: rtl/debounce_channel.sv
// One button: 2-FF synchronizer, stability counter and level FSM; all outputs registered.
// A new level is accepted DEBOUNCE_LIMIT+1 edges after it first lands in s1.
module debounce_channel
  import btn_debouncer_pkg::*;
#(
  parameter int NB_COUNTER     = NB_COUNTER_DEFAULT,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_LIMIT - 1);
  localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);

  logic                  s1;
  logic                  s2;
  state_e                state;
  logic [NB_COUNTER-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      state     <= ST_LOW;
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      s1        <= i_btn;
      s2        <= s1;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      case (state)
        ST_LOW: begin
          if (s2) begin
            state <= ST_WAIT_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          // Any glitch back to the accepted level restarts the count from scratch.
          if (!s2) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= ST_HIGH;
            cnt     <= '0;
            o_level <= 1'b1;
            o_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!s2) begin
            state <= ST_WAIT_LOW;
            cnt   <= CNT_ONE;
          end
        end
        ST_WAIT_LOW: begin
          if (s2) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_LOW;
            cnt       <= '0;
            o_level   <= 1'b0;
            o_release <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/btn_debouncer.sv
// NB_BTN independent debounce channels side by side, no cross-channel interaction.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int NB_BTN         = NB_BTN_DEFAULT,
  parameter int NB_COUNTER     = NB_COUNTER_DEFAULT,
  parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic            clock,
  input  logic            i_reset,
  btn_debouncer_if.slave  bus
);

  if ((DEBOUNCE_LIMIT < 2) || (DEBOUNCE_LIMIT > (1 << NB_COUNTER))) begin : g_bad_limit
    $error("btn_debouncer: DEBOUNCE_LIMIT out of range for NB_COUNTER");
  end

  for (genvar n = 0; n < NB_BTN; n++) begin : g_ch
    debounce_channel #(
      .NB_COUNTER     (NB_COUNTER),
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_ch (
      .clock     (clock),
      .i_reset   (i_reset),
      .i_btn     (bus.i_btn[n]),
      .o_level   (bus.o_level[n]),
      .o_press   (bus.o_press[n]),
      .o_release (bus.o_release[n])
    );
  end

endmodule
